// File: rtl/reg_file_sb_pkg.sv
// Shared constants for the scoreboarded register file: default geometry,
// the hardwired-zero register address and the reset polarity.
package reg_file_sb_pkg;

    localparam int       RF_DATA_W    = 32;
    localparam int       RF_ADDR_W    = 5;
    localparam int       RF_ZERO_ADDR = 0;
    localparam logic     RST_ACTIVE   = 1'b1;

    // True when addr names the hardwired-zero register.
    function automatic logic is_zero_addr(input logic [RF_ADDR_W-1:0] addr);
        return addr == RF_ADDR_W'(RF_ZERO_ADDR);
    endfunction

endpackage

// File: rtl/rf_wsel.sv
// Priority address match across the write ports: reports whether any enabled
// port targets match_addr_i and returns the data of the highest-index one.
module rf_wsel
    import reg_file_sb_pkg::*;
#(
    parameter int NWR    = 2,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int DATA_W = RF_DATA_W
) (
    input  logic [ADDR_W-1:0]     match_addr_i,
    input  logic [NWR-1:0]        en_i,
    input  logic [NWR*ADDR_W-1:0] addr_i,
    input  logic [NWR*DATA_W-1:0] data_i,
    output logic                  hit_o,
    output logic [DATA_W-1:0]     data_o
);

    // Later ports overwrite earlier ones, so the highest index wins.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        for (int p = 0; p < NWR; p++) begin
            if (en_i[p] && (addr_i[p*ADDR_W +: ADDR_W] == match_addr_i)) begin
                hit_o  = 1'b1;
                data_o = data_i[p*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-ported register file with a per-register pending (scoreboard) bit,
// hardwired-zero register 0 and optional same-cycle write-to-read forwarding.
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int NRD    = 4,
    parameter int NWR    = 2,
    parameter int BYPASS = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD*ADDR_W-1:0] raddr_i,
    output logic [NRD*DATA_W-1:0] rdata_o,
    output logic [NRD-1:0]        rbusy_o,
    input  logic [NWR-1:0]        we_i,
    input  logic [NWR*ADDR_W-1:0] waddr_i,
    input  logic [NWR*DATA_W-1:0] wdata_i,
    input  logic [NWR-1:0]        iss_i,
    input  logic [NWR*ADDR_W-1:0] iaddr_i,
    input  logic                  flush_i
);

    localparam int               DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(RF_ZERO_ADDR);

    logic [DATA_W-1:0] regs_rd [DEPTH];
    logic [DEPTH-1:0]  pend_rd;

    genvar gi;

    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            if (gi == RF_ZERO_ADDR) begin : g_zero
                assign regs_rd[gi] = '0;
                assign pend_rd[gi] = 1'b0;
            end else begin : g_reg
                localparam logic [ADDR_W-1:0] ENTRY = ADDR_W'(gi);

                logic [DATA_W-1:0] reg_q, reg_d;
                logic              pend_q, pend_d;
                logic              wr_hit;
                logic [DATA_W-1:0] wr_val;
                logic              iss_hit;

                rf_wsel #(
                    .NWR    (NWR),
                    .ADDR_W (ADDR_W),
                    .DATA_W (DATA_W)
                ) u_wsel (
                    .match_addr_i (ENTRY),
                    .en_i         (we_i),
                    .addr_i       (waddr_i),
                    .data_i       (wdata_i),
                    .hit_o        (wr_hit),
                    .data_o       (wr_val)
                );

                // Flush beats everything; an issue beats a completing write.
                always_comb begin
                    iss_hit = 1'b0;
                    for (int p = 0; p < NWR; p++) begin
                        if (iss_i[p] && (iaddr_i[p*ADDR_W +: ADDR_W] == ENTRY)) begin
                            iss_hit = 1'b1;
                        end
                    end
                    reg_d  = wr_hit ? wr_val : reg_q;
                    pend_d = pend_q;
                    if (flush_i) begin
                        pend_d = 1'b0;
                    end else if (iss_hit) begin
                        pend_d = 1'b1;
                    end else if (wr_hit) begin
                        pend_d = 1'b0;
                    end
                end

                always_ff @(posedge clk) begin
                    if (rst == RST_ACTIVE) begin
                        reg_q  <= '0;
                        pend_q <= 1'b0;
                    end else begin
                        reg_q  <= reg_d;
                        pend_q <= pend_d;
                    end
                end

                assign regs_rd[gi] = reg_q;
                assign pend_rd[gi] = pend_q;
            end
        end

        for (gi = 0; gi < NRD; gi++) begin : g_rport
            logic [ADDR_W-1:0] ra;
            logic              byp_hit;
            logic [DATA_W-1:0] byp_val;
            logic [DATA_W-1:0] rd;
            logic              busy;
            logic              fwd;

            assign ra = raddr_i[gi*ADDR_W +: ADDR_W];

            rf_wsel #(
                .NWR    (NWR),
                .ADDR_W (ADDR_W),
                .DATA_W (DATA_W)
            ) u_byp (
                .match_addr_i (ra),
                .en_i         (we_i),
                .addr_i       (waddr_i),
                .data_i       (wdata_i),
                .hit_o        (byp_hit),
                .data_o       (byp_val)
            );

            always_comb begin
                fwd  = (BYPASS != 0) && byp_hit && (ra != ZERO);
                rd   = regs_rd[ra];
                busy = pend_rd[ra] && !fwd;
                if (ra == ZERO) begin
                    rd = '0;
                end else if (fwd) begin
                    rd = byp_val;
                end
            end

            assign rdata_o[gi*DATA_W +: DATA_W] = rd;
            assign rbusy_o[gi]                  = busy;
        end
    endgenerate

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed table-driven bench for reg_file_sb with default parameters
// (32-bit, 32 entries, 4 read ports, 2 write/issue ports, bypass on).
module tb_reg_file_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 4;
    localparam int NW = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR*AW-1:0]  raddr_i = '0;
    logic [NR*DW-1:0]  rdata_o;
    logic [NR-1:0]     rbusy_o;
    logic [NW-1:0]     we_i = '0;
    logic [NW*AW-1:0]  waddr_i = '0;
    logic [NW*DW-1:0]  wdata_i = '0;
    logic [NW-1:0]     iss_i = '0;
    logic [NW*AW-1:0]  iaddr_i = '0;
    logic              flush_i = 1'b0;

    int compared   = 0;
    int mismatched = 0;

    reg_file_sb #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .NRD    (NR),
        .NWR    (NW),
        .BYPASS (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .raddr_i (raddr_i),
        .rdata_o (rdata_o),
        .rbusy_o (rbusy_o),
        .we_i    (we_i),
        .waddr_i (waddr_i),
        .wdata_i (wdata_i),
        .iss_i   (iss_i),
        .iaddr_i (iaddr_i),
        .flush_i (flush_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic [1:0]  iss;
        logic [4:0]  ia0, ia1;
        logic        flush;
        logic [4:0]  ra0, ra1, ra2, ra3;
        logic [31:0] er0, er1, er2, er3;
        logic [3:0]  eb;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    function automatic vec_t mk(
        input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
        input logic [4:0] wa1, input logic [31:0] wd1,
        input logic [1:0] iss, input logic [4:0] ia0, input logic [4:0] ia1,
        input logic flush,
        input logic [4:0] ra0, input logic [4:0] ra1, input logic [4:0] ra2, input logic [4:0] ra3,
        input logic [31:0] er0, input logic [31:0] er1, input logic [31:0] er2, input logic [31:0] er3,
        input logic [3:0] eb);
        vec_t v;
        v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.iss = iss; v.ia0 = ia0; v.ia1 = ia1; v.flush = flush;
        v.ra0 = ra0; v.ra1 = ra1; v.ra2 = ra2; v.ra3 = ra3;
        v.er0 = er0; v.er1 = er1; v.er2 = er2; v.er3 = er3;
        v.eb = eb;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        we_i = '0; waddr_i = '0; wdata_i = '0;
        iss_i = '0; iaddr_i = '0; flush_i = 1'b0;
    endtask

    // Drive one vector, check combinational outputs mid-cycle, then clock it in.
    task automatic apply(input vec_t v, input int idx);
        we_i    = v.we;
        waddr_i = {v.wa1, v.wa0};
        wdata_i = {v.wd1, v.wd0};
        iss_i   = v.iss;
        iaddr_i = {v.ia1, v.ia0};
        flush_i = v.flush;
        raddr_i = {v.ra3, v.ra2, v.ra1, v.ra0};
        #3;
        chk($sformatf("v%0d rdata0 r%0d", idx, v.ra0), rdata_o[0*DW +: DW], v.er0);
        chk($sformatf("v%0d rdata1 r%0d", idx, v.ra1), rdata_o[1*DW +: DW], v.er1);
        chk($sformatf("v%0d rdata2 r%0d", idx, v.ra2), rdata_o[2*DW +: DW], v.er2);
        chk($sformatf("v%0d rdata3 r%0d", idx, v.ra3), rdata_o[3*DW +: DW], v.er3);
        chk($sformatf("v%0d rbusy", idx), 32'(rbusy_o), 32'(v.eb));
        $display("vec %0d: we=%b iss=%b flush=%b ra={%0d,%0d,%0d,%0d} rbusy=%b",
                 idx, v.we, v.iss, v.flush, v.ra0, v.ra1, v.ra2, v.ra3, rbusy_o);
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    initial begin
        //            we    wa0 wd0            wa1 wd1         iss   ia0 ia1 fl  ra0 ra1 ra2 ra3 er0           er1    er2    er3    eb
        vecs[0]  = mk(2'b11, 5, 32'hA,         5, 32'hB,       2'b00, 0, 0, 0,  5,  5,  0,  6, 32'hB,        32'hB, 32'h0, 32'h0, 4'b0000);
        vecs[1]  = mk(2'b00, 0, 0,             0, 0,           2'b00, 0, 0, 0,  5,  6,  0,  4, 32'hB,        32'h0, 32'h0, 32'h0, 4'b0000);
        vecs[2]  = mk(2'b01, 0, 32'hFFFF_FFFF, 0, 0,           2'b01, 0, 0, 0,  0,  5,  0,  0, 32'h0,        32'hB, 32'h0, 32'h0, 4'b0000);
        vecs[3]  = mk(2'b00, 0, 0,             0, 0,           2'b00, 0, 0, 0,  0,  0,  0,  0, 32'h0,        32'h0, 32'h0, 32'h0, 4'b0000);
        vecs[4]  = mk(2'b00, 0, 0,             0, 0,           2'b01, 7, 0, 0,  7,  0,  0,  0, 32'h0,        32'h0, 32'h0, 32'h0, 4'b0000);
        vecs[5]  = mk(2'b00, 0, 0,             0, 0,           2'b00, 0, 0, 0,  7,  7,  5,  0, 32'h0,        32'h0, 32'hB, 32'h0, 4'b0011);
        vecs[6]  = mk(2'b10, 0, 0,             7, 32'h55,      2'b00, 0, 0, 0,  7,  1,  7,  0, 32'h55,       32'h0, 32'h55, 32'h0, 4'b0000);
        vecs[7]  = mk(2'b00, 0, 0,             0, 0,           2'b00, 0, 0, 0,  7,  0,  0,  0, 32'h55,       32'h0, 32'h0, 32'h0, 4'b0000);
        vecs[8]  = mk(2'b01, 9, 32'h99,        0, 0,           2'b10, 0, 9, 0,  9,  0,  0,  0, 32'h99,       32'h0, 32'h0, 32'h0, 4'b0000);
        vecs[9]  = mk(2'b00, 0, 0,             0, 0,           2'b00, 0, 0, 0,  9,  7,  0,  0, 32'h99,       32'h55, 32'h0, 32'h0, 4'b0001);
        vecs[10] = mk(2'b00, 0, 0,             0, 0,           2'b11, 3, 4, 0,  3,  4,  9,  0, 32'h0,        32'h0, 32'h99, 32'h0, 4'b0100);
        vecs[11] = mk(2'b00, 0, 0,             0, 0,           2'b00, 0, 0, 0,  3,  4,  9,  5, 32'h0,        32'h0, 32'h99, 32'hB, 4'b0111);
        vecs[12] = mk(2'b10, 0, 0,            10, 32'h10,      2'b01, 6, 0, 1,  3,  4,  6,  9, 32'h0,        32'h0, 32'h0, 32'h99, 4'b1011);
        vecs[13] = mk(2'b00, 0, 0,             0, 0,           2'b00, 0, 0, 0,  3,  4,  6, 10, 32'h0,        32'h0, 32'h0, 32'h10, 4'b0000);
        vecs[14] = mk(2'b11, 12, 32'hC0,      12, 32'hC1,      2'b00, 0, 0, 0, 12,  9,  0,  0, 32'hC1,       32'h99, 32'h0, 32'h0, 4'b0000);
        vecs[15] = mk(2'b00, 0, 0,             0, 0,           2'b00, 0, 0, 0, 12,  9,  0,  0, 32'hC1,       32'h99, 32'h0, 32'h0, 4'b0000);
        vecs[16] = mk(2'b10, 0, 0,            11, 32'h11,      2'b01, 11, 0, 0, 11, 0,  0,  0, 32'h11,       32'h0, 32'h0, 32'h0, 4'b0000);
        vecs[17] = mk(2'b00, 0, 0,             0, 0,           2'b00, 0, 0, 0, 11, 12,  0,  0, 32'h11,       32'hC1, 32'h0, 32'h0, 4'b0001);

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Every register reads zero and nothing is busy right after reset.
        for (int base = 0; base < 32; base += 4) begin
            raddr_i = {5'(base + 3), 5'(base + 2), 5'(base + 1), 5'(base)};
            #1;
            for (int k = 0; k < NR; k++) begin
                chk($sformatf("reset rdata r%0d", base + k), rdata_o[k*DW +: DW], 32'h0);
            end
            chk($sformatf("reset rbusy r%0d..r%0d", base, base + 3), 32'(rbusy_o), 32'h0);
            $display("reset read r%0d..r%0d rbusy=%b", base, base + 3, rbusy_o);
        end
        @(posedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            apply(vecs[i], i);
        end

        // Reset in mid-operation: r11 is pending, and a write and issue
        // presented during the reset cycle must be ignored.
        we_i    = 2'b01;
        waddr_i = {5'd0, 5'd22};
        wdata_i = {32'h0, 32'h22};
        iss_i   = 2'b10;
        iaddr_i = {5'd23, 5'd0};
        rst     = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_inputs();
        raddr_i = {5'd12, 5'd23, 5'd22, 5'd11};
        #2;
        chk("midreset rdata r11", rdata_o[0*DW +: DW], 32'h0);
        chk("midreset rdata r22", rdata_o[1*DW +: DW], 32'h0);
        chk("midreset rdata r23", rdata_o[2*DW +: DW], 32'h0);
        chk("midreset rdata r12", rdata_o[3*DW +: DW], 32'h0);
        chk("midreset rbusy", 32'(rbusy_o), 32'h0);
        $display("mid-op reset: rbusy=%b", rbusy_o);

        // Write then issue the same register on consecutive cycles after reset.
        we_i = 2'b01; waddr_i = {5'd0, 5'd20}; wdata_i = {32'h0, 32'h2020};
        @(posedge clk);
        #1;
        idle_inputs();
        iss_i = 2'b01; iaddr_i = {5'd0, 5'd20};
        @(posedge clk);
        #1;
        idle_inputs();
        raddr_i = {5'd0, 5'd0, 5'd21, 5'd20};
        #2;
        chk("post-reset rdata r20", rdata_o[0*DW +: DW], 32'h2020);
        chk("post-reset rbusy", 32'(rbusy_o), 32'h1);
        $display("post-reset write/issue r20: rdata=0x%08h rbusy=%b", rdata_o[0*DW +: DW], rbusy_o);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
